// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: instruction word type plus the loader's control, stream and memory-write bundle
package instr_mem_loader_pkg;
    typedef logic [31:0] instruction_s;
endpackage

interface instr_mem_loader_if #(parameter int addr_width_p = 10) ();
    logic                             start_i;
    logic [addr_width_p-1:0]          base_addr_i;
    logic [addr_width_p:0]            count_i;
    logic                             abort_i;
    logic                             data_v_i;
    instr_mem_loader_pkg::instruction_s data_i;
    logic                             ready_o;
    logic [addr_width_p-1:0]          mem_addr_o;
    instr_mem_loader_pkg::instruction_s mem_instr_o;
    logic                             mem_wen_o;
    logic                             busy_o;
    logic                             done_o;
    logic [addr_width_p:0]            loaded_cnt_o;

    modport master (
        output start_i, base_addr_i, count_i, abort_i, data_v_i, data_i,
        input  ready_o, mem_addr_o, mem_instr_o, mem_wen_o, busy_o, done_o, loaded_cnt_o
    );

    modport slave (
        input  start_i, base_addr_i, count_i, abort_i, data_v_i, data_i,
        output ready_o, mem_addr_o, mem_instr_o, mem_wen_o, busy_o, done_o, loaded_cnt_o
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams valid/ready instruction beats into consecutive memory addresses
module instr_mem_loader #(
    parameter int addr_width_p = 10
) (
    input logic                clk,
    input logic                reset_n,
    instr_mem_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    localparam logic [addr_width_p:0] one_c = {{addr_width_p{1'b0}}, 1'b1};

    state_e                             state_q, state_d;
    logic [addr_width_p-1:0]            addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [addr_width_p:0]              rem_q, rem_d, cnt_q, cnt_d;
    instr_mem_loader_pkg::instruction_s instr_q, instr_d;
    logic                               wen_q, wen_d, ready, accept;

    assign ready  = (state_q == LOAD) && !bus.abort_i;
    assign accept = bus.data_v_i && ready;

    // Next state and counters; the write port registers each accepted beat for one cycle
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        wen_d      = accept;
        mem_addr_d = accept ? addr_q : mem_addr_q;
        instr_d    = accept ? bus.data_i : instr_q;
        if (state_q == LOAD) begin
            if (bus.abort_i) begin
                state_d = IDLE;
            end else if (accept) begin
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (rem_q == one_c) ? DONE : LOAD;
            end
        end else if (bus.start_i) begin
            state_d = (bus.count_i != '0) ? LOAD : DONE;
            addr_d  = bus.base_addr_i;
            rem_d   = bus.count_i;
            cnt_d   = '0;
        end
    end

    // State and output registers; reset also kills a pending write at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            wen_q      <= 1'b0;
            mem_addr_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            wen_q      <= wen_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
        end
    end

    assign bus.ready_o      = ready;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_instr_o  = instr_q;
    assign bus.mem_wen_o    = wen_q;
    assign bus.busy_o       = (state_q == LOAD);
    assign bus.done_o       = (state_q == DONE);
    assign bus.loaded_cnt_o = cnt_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized scenarios checked cycle by cycle against a load-progress model
module tb_instr_mem_loader;
    localparam int aw_c    = 10;
    localparam int depth_c = 1 << aw_c;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    instr_mem_loader_if #(.addr_width_p(aw_c)) bus ();

    instr_mem_loader #(.addr_width_p(aw_c)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model: a load is a base, a requested count and how many beats have gone in so far
    bit          m_load, m_done;
    int          m_base, m_count, m_loaded;
    bit          pend;
    int          pend_addr;
    logic [31:0] pend_data;
    int          wlog[$];

    always @(negedge clk) if (reset_n && bus.mem_wen_o) wlog.push_back(int'(bus.mem_addr_o));

    task automatic model_reset();
        m_load = 0; m_done = 0; m_base = 0; m_count = 0; m_loaded = 0; pend = 0;
    endtask

    // One clock: drive inputs just after posedge, check at negedge, advance the model
    task automatic step(input bit v, input logic [31:0] d, input bit ab, input bit st,
                        input int b, input int c);
        bit exp_ready, acc;
        bus.data_v_i    = v;
        bus.data_i      = d;
        bus.abort_i     = ab;
        bus.start_i     = st;
        bus.base_addr_i = b[aw_c-1:0];
        bus.count_i     = c[aw_c:0];
        @(negedge clk);
        exp_ready = m_load && !ab;
        n_cmp++; if (bus.ready_o !== exp_ready) begin n_err++; $display("FAIL ready: got %b want %b", bus.ready_o, exp_ready); end
        n_cmp++; if (bus.busy_o !== m_load) begin n_err++; $display("FAIL busy: got %b want %b", bus.busy_o, m_load); end
        n_cmp++; if (bus.done_o !== m_done) begin n_err++; $display("FAIL done: got %b want %b", bus.done_o, m_done); end
        n_cmp++; if (int'(bus.loaded_cnt_o) != m_loaded) begin n_err++; $display("FAIL loaded_cnt: got %0d want %0d", bus.loaded_cnt_o, m_loaded); end
        n_cmp++; if (bus.mem_wen_o !== pend) begin n_err++; $display("FAIL wen: got %b want %b", bus.mem_wen_o, pend); end
        if (pend) begin
            n_cmp++; if (int'(bus.mem_addr_o) != pend_addr) begin n_err++; $display("FAIL mem_addr: got %h want %h", bus.mem_addr_o, pend_addr); end
            n_cmp++; if (bus.mem_instr_o !== pend_data) begin n_err++; $display("FAIL mem_instr: got %h want %h", bus.mem_instr_o, pend_data); end
        end
        acc       = v && exp_ready;
        pend      = acc;
        pend_addr = (m_base + m_loaded) % depth_c;
        pend_data = d;
        if (m_load) begin
            if (ab) m_load = 0;
            else if (acc) begin
                m_loaded++;
                if (m_loaded == m_count) begin m_load = 0; m_done = 1; end
            end
        end else if (st) begin
            m_loaded = 0;
            if (c != 0) begin m_load = 1; m_done = 0; m_base = b; m_count = c; end
            else m_done = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic check_log(input string name, input int exp[$]);
        n_cmp++;
        if (wlog.size() != exp.size()) begin
            n_err++; $display("FAIL %s write count: got %0d want %0d", name, wlog.size(), exp.size());
        end else foreach (exp[i]) begin
            n_cmp++;
            if (wlog[i] != exp[i]) begin n_err++; $display("FAIL %s write %0d addr: got %h want %h", name, i, wlog[i], exp[i]); end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        n_cmp++;
        if ({bus.ready_o, bus.mem_wen_o, bus.busy_o, bus.done_o} !== 4'b0 || bus.mem_addr_o !== '0 ||
            bus.mem_instr_o !== '0 || bus.loaded_cnt_o !== '0) begin
            n_err++;
            $display("FAIL %s outputs: got rdy=%b wen=%b busy=%b done=%b addr=%h instr=%h cnt=%0d want all zero",
                     name, bus.ready_o, bus.mem_wen_o, bus.busy_o, bus.done_o, bus.mem_addr_o, bus.mem_instr_o, bus.loaded_cnt_o);
        end
    endtask

    task automatic test_reset();
        {bus.start_i, bus.abort_i, bus.data_v_i} = 3'b0;
        bus.base_addr_i = '0; bus.count_i = '0; bus.data_i = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        idle(2);
    endtask

    task automatic test_basic();
        wlog.delete();
        step(0, 0, 0, 1, 'h010, 3);
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, 0, 0);
        idle(3);
        check_log("basic", '{'h010, 'h011, 'h012});
        n_cmp++; if (!bus.done_o || bus.loaded_cnt_o != 3) begin n_err++; $display("FAIL basic final: got done=%b cnt=%0d want 1 3", bus.done_o, bus.loaded_cnt_o); end
    endtask

    task automatic test_wrap();
        wlog.delete();
        step(0, 0, 0, 1, 'h3FE, 4);
        for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0, 0, 0);
        idle(2);
        check_log("wrap", '{'h3FE, 'h3FF, 'h000, 'h001});
    endtask

    task automatic test_gaps();
        wlog.delete();
        step(0, 0, 0, 1, 'h123, 5);
        for (int i = 0; i < 15; i++) step(i % 3 == 0, $urandom, 0, 0, 0, 0);
        idle(2);
        check_log("gaps", '{'h123, 'h124, 'h125, 'h126, 'h127});
    endtask

    task automatic test_zero();
        wlog.delete();
        step(0, 0, 0, 1, int'($urandom_range(0, depth_c - 1)), 0);
        idle(3);
        check_log("zero", '{});
        n_cmp++; if (!bus.done_o || bus.loaded_cnt_o != 0) begin n_err++; $display("FAIL zero final: got done=%b cnt=%0d want 1 0", bus.done_o, bus.loaded_cnt_o); end
    endtask

    task automatic test_abort();
        wlog.delete();
        step(0, 0, 0, 1, 'h200, 8);
        step(1, $urandom, 0, 0, 0, 0);
        step(1, $urandom, 0, 1, 'h050, 2);
        step(1, $urandom, 0, 0, 0, 0);
        step(1, $urandom, 1, 0, 0, 0);
        step(1, $urandom, 1, 0, 0, 0);
        idle(2);
        check_log("abort", '{'h200, 'h201, 'h202});
        n_cmp++; if (bus.busy_o || bus.done_o || bus.loaded_cnt_o != 3) begin n_err++; $display("FAIL abort final: got busy=%b done=%b cnt=%0d want 0 0 3", bus.busy_o, bus.done_o, bus.loaded_cnt_o); end
    endtask

    task automatic test_reset_mid_load();
        step(0, 0, 0, 1, 'h155, 6);
        step(1, $urandom, 0, 0, 0, 0);
        step(1, $urandom, 0, 0, 0, 0);
        bus.data_v_i = 1'b1;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("reset mid-load");
        bus.data_v_i = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        idle(2);
        wlog.delete();
        step(0, 0, 0, 1, 0, 2);
        step(1, $urandom, 0, 0, 0, 0);
        step(1, $urandom, 0, 0, 0, 0);
        idle(2);
        check_log("after reset", '{'h000, 'h001});
    endtask

    task automatic test_random();
        for (int l = 0; l < 6; l++) begin
            step(0, 0, 0, 1, int'($urandom_range(0, depth_c - 1)), int'($urandom_range(1, 12)));
            for (int i = 0; i < 60 && m_load; i++)
                step($urandom % 2, $urandom, ($urandom % 25) == 0, $urandom % 2, int'($urandom_range(0, depth_c - 1)), 3);
            idle(2);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_wrap();
        test_gaps();
        test_zero();
        test_abort();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter addr_width_p, default 10, SHALL set the instruction memory address width; depth is 2**addr_width_p.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-004 Port start_i, input, 1 bit, SHALL be a single-cycle request to begin a load.
REQ-005 Port base_addr_i, input, addr_width_p bits, SHALL be the first write address, sampled with start_i.
REQ-006 Port count_i, input, addr_width_p+1 bits, SHALL be the number of instructions to load, sampled with start_i.
REQ-007 Port abort_i, input, 1 bit, SHALL request termination of an active load.
REQ-008 Port data_v_i, input, 1 bit, SHALL mark data_i valid.
REQ-009 Port data_i, input, instruction_s, SHALL be the incoming instruction word.
REQ-010 Port ready_o, output, 1 bit, SHALL indicate the loader accepts data_i this cycle.
REQ-011 Port mem_addr_o, output, addr_width_p bits, SHALL drive the memory addr_i.
REQ-012 Port mem_instr_o, output, instruction_s, SHALL drive the memory instruction_i.
REQ-013 Port mem_wen_o, output, 1 bit, SHALL drive the memory wen_i.
REQ-014 Port busy_o, output, 1 bit, SHALL be high while in LOAD.
REQ-015 Port done_o, output, 1 bit, SHALL be high while in DONE.
REQ-016 Port loaded_cnt_o, output, addr_width_p+1 bits, SHALL report the beats accepted in the current or last load.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, DONE.
REQ-018 IDLE/DONE + start_i with count_i != 0 -> LOAD; capture base_addr_i into the address counter, count_i into the remaining counter, clear loaded_cnt_o.
REQ-019 IDLE/DONE + start_i with count_i == 0 -> DONE; loaded_cnt_o = 0; no memory write.
REQ-020 start_i in LOAD SHALL be ignored.
REQ-021 ready_o = (state == LOAD) && !abort_i, combinational.
REQ-022 Handshake: a beat is accepted when data_v_i && ready_o; data_v_i without ready_o SHALL have no effect.
REQ-023 An accepted beat SHALL produce exactly one memory write the next cycle: mem_wen_o = 1, mem_addr_o = current address, mem_instr_o = data_i (registered outputs, 1-cycle latency).
REQ-024 mem_wen_o SHALL be 0 in every cycle not following an accepted beat; mem_addr_o/mem_instr_o hold their last values.
REQ-025 Per accepted beat: address += 1 modulo 2**addr_width_p (wraps from all-ones to 0), remaining -= 1, loaded_cnt_o += 1.
REQ-026 Accepting the beat with remaining == 1 -> DONE next cycle; ready_o is low from that cycle on.
REQ-027 abort_i in LOAD -> IDLE next cycle; no beat is accepted that cycle; a write from a beat accepted in the previous cycle SHALL still complete; loaded_cnt_o holds.
REQ-028 abort_i in IDLE or DONE SHALL be ignored.
REQ-029 Gaps in data_v_i SHALL stall the load indefinitely without writes.
REQ-030 DONE holds until start_i; loaded_cnt_o holds its final value.

Reset
REQ-031 While reset_n == 0: state = IDLE, ready_o = 0, mem_wen_o = 0, mem_addr_o = 0, mem_instr_o = 0, busy_o = 0, done_o = 0, loaded_cnt_o = 0, internal counters = 0.
REQ-032 Reset asserted mid-LOAD SHALL drop any pending write immediately (mem_wen_o = 0 asynchronously); after release, the loader SHALL sit in IDLE awaiting start_i.

Verification
REQ-033 start base=0x010, count=3, data_v continuous A,B,C -> writes 0x010=A, 0x011=B, 0x012=C on consecutive cycles starting 1 cycle after the first accept; done_o=1, loaded_cnt_o=3.
REQ-034 start base=0x3FE, count=4 -> writes to 0x3FE, 0x3FF, 0x000, 0x001 (wrap).
REQ-035 count=5, data_v toggled 1,0,0,1,... -> exactly 5 writes, none during gaps, addresses contiguous.
REQ-036 count=0 start -> DONE next cycle, mem_wen_o never 1, loaded_cnt_o=0.
REQ-037 count=8, abort_i with data_v high after 3 accepts -> beat not accepted, 3 writes total, IDLE, loaded_cnt_o=3; start_i during LOAD ignored.
REQ-038 reset_n low mid-load after 2 accepts -> all outputs 0 immediately, IDLE after release, new start at base=0 writes from 0x000.
